chacha20_poly1305_ctrl: RTL and testbench
=========================================

Name: chacha20_poly1305_ctrl

Overview:
- Parametrised AEAD sequencing controller for ChaCha20-Poly1305 (RFC 8439); successor to the fixed idle/init control FSM.
- Drives an external ChaCha20 block engine and an external Poly1305 MAC engine through one message:
  - Poly1305 key generation (block 0)
  - AAD absorption
  - Keystream generation plus ciphertext absorption (blocks 1..n)
  - Length block and tag finalisation
- Compares the tag for decryption. Sits between the host register interface and the two crypto cores. No data path; control only.

Parameters:
CTR_WIDTH, 32, ChaCha20 block counter width
LEN_WIDTH, 64, width of AAD/data byte-length inputs
TAG_WIDTH, 128, Poly1305 tag width

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
init  in  1  start new message (pulse)
encdec  in  1  1=encrypt, 0=decrypt; sampled at init
aad_len  in  LEN_WIDTH  AAD byte count; sampled at init
data_len  in  LEN_WIDTH  payload byte count; sampled at init
next  in  1  host has presented next 64-byte chunk (pulse)
ready  out  1  idle, or waiting for next chunk
phase  out  2  0=setup/idle, 1=AAD, 2=data, 3=length/final
cc_init  out  1  pulse: ChaCha key/nonce load + block at cc_ctr
cc_next  out  1  pulse: compute block at cc_ctr
cc_ctr  out  CTR_WIDTH  block counter for cc_init/cc_next
cc_ready  in  1  ChaCha engine idle/result valid
p_init  out  1  pulse: load Poly1305 key from keystream block 0
p_next  out  1  pulse: absorb current chunk
p_final  out  1  pulse: finalise tag
p_blen  out  7  bytes absorbed by p_next (16,32,48,64); datapath zero-pads
p_ready  in  1  Poly1305 engine idle/result valid
p1305_tag  in  TAG_WIDTH  tag from Poly1305 engine
tag_in  in  TAG_WIDTH  expected tag (decrypt)
tag_valid  out  1  tag comparison complete
tag_correct  out  1  decrypt: p1305_tag == tag_in; encrypt: 0
error  out  1  length/counter overflow; message aborted

Behaviour:
- Reset (synchronous, active-high) forces state IDLE and all outputs to 0, except ready=1; cc_ctr=0.
- All pulse outputs are registered and high for exactly one cycle.
- After any pulse the FSM waits for the matching *_ready. *_ready is ignored in the pulse cycle and checked from the next cycle on.
- States:
  - IDLE: ready=1.
    - init latches encdec and lengths, clears tag_valid/tag_correct/error.
    - If data_len > (2^CTR_WIDTH−1)*64: set error, go to IDLE. Otherwise go to KEYGEN.
  - KEYGEN: cc_init with cc_ctr=0; wait cc_ready → PINIT.
  - PINIT: p_init; wait p_ready. Then go to AAD_WAIT if aad_len>0, else DATA_WAIT if data_len>0, else LEN.
  - AAD_WAIT: ready=1, phase=1; next → AAD_MAC.
  - AAD_MAC: p_next with p_blen = min(64, ceil16(aad_rem)); aad_rem -= min(64, aad_rem); wait p_ready. Then AAD_WAIT if aad_rem>0, else DATA_WAIT if data_len>0, else LEN.
  - DATA_WAIT: ready=1, phase=2; next → DATA_KS.
  - DATA_KS: cc_next with cc_ctr = current counter (first data block=1); wait cc_ready → DATA_MAC.
  - DATA_MAC: p_next with p_blen = min(64, ceil16(data_rem)); data_rem -= min(64, data_rem); counter++; wait p_ready.
    - If data_rem>0 and counter wrapped to 0: error=1, → IDLE.
    - Else if data_rem>0: → DATA_WAIT; else → LEN.
  - LEN: p_next with p_blen=16 (le64(aad_len)||le64(data_len) supplied by datapath); wait p_ready → FINAL.
  - FINAL: p_final; wait p_ready. Then register tag_correct = ~encdec & (p1305_tag==tag_in), set tag_valid=1, → IDLE.
- tag_valid/tag_correct hold until next init or reset.
- init outside IDLE is ignored. next outside *_WAIT is ignored.
- If init and next are both asserted in IDLE, init wins.
- Reset mid-message aborts immediately to IDLE; no further pulses are issued.
- phase=0 in IDLE/KEYGEN/PINIT, 3 in LEN/FINAL.
- Latency with engines that ready 1 cycle after a pulse: init→first ready in *_WAIT = 5 cycles; last next→tag_valid = 8 cycles (data path).

Test Plan:
- RFC 8439 §2.8.2 vector, encrypt, aad_len=12, data_len=114 → one AAD p_next blen=16; data cc_ctr 1,2 with p_blen 64,64; LEN blen=16; tag 1ae10b594f09e26a7e902ecbd0600691, tag_correct=0, tag_valid=1.
- Same vector, decrypt, tag_in = correct tag → tag_correct=1. Flip tag_in bit 0 → tag_correct=0, tag_valid=1.
- aad_len=0, data_len=0 → KEYGEN, PINIT, LEN, FINAL only; no cc_next; ready low until tag_valid.
- CTR_WIDTH=2, data_len=193 → error at init, no cc_init issued. data_len=192 → cc_ctr 1,2,3 then completes without error.
- reset asserted during DATA_KS → next cycle ready=1, all pulses 0, tag_valid=0; a fresh init then completes normally.
- init pulsed during AAD_WAIT and next pulsed during DATA_KS → both ignored; cc_ctr sequence and pulse count unchanged.

Source files
------------

// File: rtl/chacha20_poly1305_ctrl.sv
// ChaCha20-Poly1305 AEAD sequencing controller.
//
// Walks one message through the external ChaCha20 block engine and the
// external Poly1305 engine: one-time key block, AAD absorption, keystream
// and ciphertext absorption, the length block and tag finalisation. For
// decryption it compares the finished tag with the expected one. It carries
// no data; the datapath supplies the actual bytes for every pulse.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   init, encdec           start a message (pulse); 1=encrypt, 0=decrypt
//   aad_len, data_len      byte counts, captured together with init
//   next                   host has presented the next 64-byte chunk
//   ready, phase           idle/waiting for a chunk; 0 setup,1 AAD,2 data,3 final
//   cc_init, cc_next       ChaCha20 pulses, block number on cc_ctr
//   cc_ready               ChaCha20 engine idle / result valid
//   p_init, p_next,
//   p_final, p_blen        Poly1305 pulses, p_blen = bytes absorbed by p_next
//   p_ready, p1305_tag     Poly1305 engine idle / result valid, computed tag
//   tag_in                 expected tag for decryption
//   tag_valid, tag_correct tag comparison result (held until next init)
//   error                  length/counter overflow, message aborted

module chacha20_poly1305_ctrl #(
  parameter int CTR_WIDTH = 32,
  parameter int LEN_WIDTH = 64,
  parameter int TAG_WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 encdec,
  input  logic [LEN_WIDTH-1:0] aad_len,
  input  logic [LEN_WIDTH-1:0] data_len,
  input  logic                 next,
  output logic                 ready,
  output logic [1:0]           phase,
  output logic                 cc_init,
  output logic                 cc_next,
  output logic [CTR_WIDTH-1:0] cc_ctr,
  input  logic                 cc_ready,
  output logic                 p_init,
  output logic                 p_next,
  output logic                 p_final,
  output logic [6:0]           p_blen,
  input  logic                 p_ready,
  input  logic [TAG_WIDTH-1:0] p1305_tag,
  input  logic [TAG_WIDTH-1:0] tag_in,
  output logic                 tag_valid,
  output logic                 tag_correct,
  output logic                 error
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_KEYGEN,
    S_PINIT,
    S_AAD_WAIT,
    S_AAD_MAC,
    S_DATA_WAIT,
    S_DATA_KS,
    S_DATA_MAC,
    S_LEN,
    S_FINAL
  } state_t;

  // Largest payload that fits in counters 1..2^CTR_WIDTH-1 (block 0 is the key).
  localparam int XW = LEN_WIDTH + CTR_WIDTH + 7;
  localparam logic [XW-1:0] MAX_DATA = XW'({CTR_WIDTH{1'b1}}) << 6;

  state_t               state;
  logic                 mode_enc;
  logic [LEN_WIDTH-1:0] aad_rem;
  logic [LEN_WIDTH-1:0] data_rem;

  // Bytes consumed from the remaining count by one chunk.
  function automatic logic [LEN_WIDTH-1:0] chunk_step(input logic [LEN_WIDTH-1:0] rem);
    if (rem >= LEN_WIDTH'(64)) return LEN_WIDTH'(64);
    return rem;
  endfunction

  // Bytes handed to Poly1305 for one chunk: the tail is zero-padded to 16.
  function automatic logic [6:0] chunk_blen(input logic [LEN_WIDTH-1:0] rem);
    logic [6:0] up;
    if (rem >= LEN_WIDTH'(64)) return 7'd64;
    up = {1'b0, rem[5:0]} + 7'd15;
    return {up[6:4], 4'b0000};
  endfunction

  // Every pulse register doubles as the "pulse cycle" marker: the engine
  // ready flag is only trusted once the pulse has dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      ready       <= 1'b1;
      phase       <= 2'd0;
      cc_init     <= 1'b0;
      cc_next     <= 1'b0;
      cc_ctr      <= '0;
      p_init      <= 1'b0;
      p_next      <= 1'b0;
      p_final     <= 1'b0;
      p_blen      <= 7'd0;
      tag_valid   <= 1'b0;
      tag_correct <= 1'b0;
      error       <= 1'b0;
      mode_enc    <= 1'b0;
      aad_rem     <= '0;
      data_rem    <= '0;
    end else begin
      cc_init <= 1'b0;
      cc_next <= 1'b0;
      p_init  <= 1'b0;
      p_next  <= 1'b0;
      p_final <= 1'b0;

      case (state)
        S_IDLE: begin
          if (init) begin
            mode_enc    <= encdec;
            aad_rem     <= aad_len;
            data_rem    <= data_len;
            tag_valid   <= 1'b0;
            tag_correct <= 1'b0;
            cc_ctr      <= '0;
            if (XW'(data_len) > MAX_DATA) begin
              error <= 1'b1;
            end else begin
              error   <= 1'b0;
              state   <= S_KEYGEN;
              cc_init <= 1'b1;
              ready   <= 1'b0;
              phase   <= 2'd0;
            end
          end
        end

        S_KEYGEN: begin
          if (!cc_init && cc_ready) begin
            state  <= S_PINIT;
            p_init <= 1'b1;
            cc_ctr <= CTR_WIDTH'(1);
          end
        end

        // Remaining counts are already decremented when p_next is issued,
        // so PINIT and AAD_MAC share the same routing decision.
        S_PINIT, S_AAD_MAC: begin
          if (!p_init && !p_next && p_ready) begin
            if (aad_rem != '0) begin
              state <= S_AAD_WAIT;
              ready <= 1'b1;
              phase <= 2'd1;
            end else if (data_rem != '0) begin
              state <= S_DATA_WAIT;
              ready <= 1'b1;
              phase <= 2'd2;
            end else begin
              state  <= S_LEN;
              p_next <= 1'b1;
              p_blen <= 7'd16;
              phase  <= 2'd3;
            end
          end
        end

        S_AAD_WAIT: begin
          if (next) begin
            state   <= S_AAD_MAC;
            ready   <= 1'b0;
            p_next  <= 1'b1;
            p_blen  <= chunk_blen(aad_rem);
            aad_rem <= aad_rem - chunk_step(aad_rem);
          end
        end

        S_DATA_WAIT: begin
          if (next) begin
            state   <= S_DATA_KS;
            ready   <= 1'b0;
            cc_next <= 1'b1;
          end
        end

        S_DATA_KS: begin
          if (!cc_next && cc_ready) begin
            state    <= S_DATA_MAC;
            p_next   <= 1'b1;
            p_blen   <= chunk_blen(data_rem);
            data_rem <= data_rem - chunk_step(data_rem);
            cc_ctr   <= cc_ctr + CTR_WIDTH'(1);
          end
        end

        S_DATA_MAC: begin
          if (!p_next && p_ready) begin
            if (data_rem != '0 && cc_ctr == '0) begin
              // Counter wrapped with payload left: keystream would repeat.
              state <= S_IDLE;
              error <= 1'b1;
              ready <= 1'b1;
              phase <= 2'd0;
            end else if (data_rem != '0) begin
              state <= S_DATA_WAIT;
              ready <= 1'b1;
            end else begin
              state  <= S_LEN;
              p_next <= 1'b1;
              p_blen <= 7'd16;
              phase  <= 2'd3;
            end
          end
        end

        S_LEN: begin
          if (!p_next && p_ready) begin
            state   <= S_FINAL;
            p_final <= 1'b1;
          end
        end

        S_FINAL: begin
          if (!p_final && p_ready) begin
            state       <= S_IDLE;
            tag_valid   <= 1'b1;
            tag_correct <= ~mode_enc & (p1305_tag == tag_in);
            ready       <= 1'b1;
            phase       <= 2'd0;
          end
        end

        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
          phase <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chacha20_poly1305_ctrl.sv
// Testbench for chacha20_poly1305_ctrl: models both crypto engines with
// random busy times, logs every pulse, and compares the pulse stream and
// final status against a message-level reference built from byte counts.

module tb_chacha20_poly1305_ctrl;

  localparam int CW = 2;
  localparam int LW = 64;
  localparam int TW = 128;
  localparam logic [TW-1:0] RFC_TAG = 128'h1ae10b594f09e26a7e902ecbd0600691;

  logic          clk = 1'b0;
  logic          reset;
  logic          init;
  logic          encdec;
  logic [LW-1:0] aad_len;
  logic [LW-1:0] data_len;
  logic          next;
  logic          ready;
  logic [1:0]    phase;
  logic          cc_init;
  logic          cc_next;
  logic [CW-1:0] cc_ctr;
  logic          cc_ready;
  logic          p_init;
  logic          p_next;
  logic          p_final;
  logic [6:0]    p_blen;
  logic          p_ready;
  logic [TW-1:0] p1305_tag;
  logic [TW-1:0] tag_in;
  logic          tag_valid;
  logic          tag_correct;
  logic          error;

  chacha20_poly1305_ctrl #(
    .CTR_WIDTH(CW),
    .LEN_WIDTH(LW),
    .TAG_WIDTH(TW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .init       (init),
    .encdec     (encdec),
    .aad_len    (aad_len),
    .data_len   (data_len),
    .next       (next),
    .ready      (ready),
    .phase      (phase),
    .cc_init    (cc_init),
    .cc_next    (cc_next),
    .cc_ctr     (cc_ctr),
    .cc_ready   (cc_ready),
    .p_init     (p_init),
    .p_next     (p_next),
    .p_final    (p_final),
    .p_blen     (p_blen),
    .p_ready    (p_ready),
    .p1305_tag  (p1305_tag),
    .tag_in     (tag_in),
    .tag_valid  (tag_valid),
    .tag_correct(tag_correct),
    .error      (error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Event word: kind, phase, counter, byte length.
  localparam int K_CCI = 0, K_CCN = 1, K_PI = 2, K_PN = 3, K_PF = 4;

  function automatic logic [63:0] mk_ev(input int kind, input int ph, input longint ctr, input int blen);
    return {8'(kind), 8'(ph), 32'(ctr), 16'(blen)};
  endfunction

  // Engine models and pulse logger.
  int            max_busy = 3;
  int            cc_cnt   = 0;
  int            p_cnt    = 0;
  int            viol     = 0;
  bit            fin_pend = 1'b0;
  logic [TW-1:0] tag_real = '0;
  logic [63:0]   ev_q[$];

  always @(posedge clk) begin
    if (reset) begin
      cc_cnt    = 0;
      p_cnt     = 0;
      fin_pend  = 1'b0;
      cc_ready  <= 1'b1;
      p_ready   <= 1'b1;
      p1305_tag <= '0;
    end else begin
      if (cc_init) ev_q.push_back(mk_ev(K_CCI, int'(phase), longint'(cc_ctr), 0));
      if (cc_next) ev_q.push_back(mk_ev(K_CCN, int'(phase), longint'(cc_ctr), 0));
      if (p_init)  ev_q.push_back(mk_ev(K_PI,  int'(phase), 0, 0));
      if (p_next)  ev_q.push_back(mk_ev(K_PN,  int'(phase), 0, int'(p_blen)));
      if (p_final) ev_q.push_back(mk_ev(K_PF,  int'(phase), 0, 0));

      if (cc_init || cc_next) begin
        if (cc_cnt != 0 || (cc_init && cc_next)) viol++;
        cc_cnt = int'($urandom_range(0, max_busy));
        cc_ready <= (cc_cnt == 0);
      end else if (cc_cnt > 0) begin
        cc_cnt--;
        cc_ready <= (cc_cnt == 0);
      end

      if (p_init || p_next || p_final) begin
        if (p_cnt != 0 || (int'(p_init) + int'(p_next) + int'(p_final)) > 1) viol++;
        p_cnt = int'($urandom_range(0, max_busy));
        p_ready <= (p_cnt == 0);
        if (p_final) begin
          fin_pend = (p_cnt != 0);
          p1305_tag <= (p_cnt == 0) ? tag_real : ~tag_real;
        end
      end else if (p_cnt > 0) begin
        p_cnt--;
        p_ready <= (p_cnt == 0);
        if (p_cnt == 0 && fin_pend) begin
          p1305_tag <= tag_real;
          fin_pend = 1'b0;
        end
      end
    end
  end

  // Run one message and compare against the reference.
  task automatic run_msg(input bit enc, input int aad, input int dl, input logic [TW-1:0] tg,
                         input bit match, input string nm, output int lat);
    logic [63:0] exp_q[$];
    int  rem, ctr, b, ev_start, viol0;
    bit  exp_err, done, bad_ready;

    exp_err = (dl > ((1 << CW) - 1) * 64);
    if (!exp_err) begin
      exp_q.push_back(mk_ev(K_CCI, 0, 0, 0));
      exp_q.push_back(mk_ev(K_PI, 0, 0, 0));
      rem = aad;
      while (rem > 0) begin
        b = (rem >= 64) ? 64 : ((rem + 15) / 16) * 16;
        exp_q.push_back(mk_ev(K_PN, 1, 0, b));
        rem -= (rem >= 64) ? 64 : rem;
      end
      rem = dl;
      ctr = 1;
      while (rem > 0) begin
        b = (rem >= 64) ? 64 : ((rem + 15) / 16) * 16;
        exp_q.push_back(mk_ev(K_CCN, 2, longint'(ctr), 0));
        exp_q.push_back(mk_ev(K_PN, 2, 0, b));
        rem -= (rem >= 64) ? 64 : rem;
        ctr++;
      end
      exp_q.push_back(mk_ev(K_PN, 3, 0, 16));
      exp_q.push_back(mk_ev(K_PF, 3, 0, 0));
    end

    ev_start  = ev_q.size();
    viol0     = viol;
    tag_real  = tg;
    lat       = -1;
    done      = 1'b0;
    bad_ready = 1'b0;

    @(negedge clk);
    encdec   = enc;
    aad_len  = LW'(aad);
    data_len = LW'(dl);
    tag_in   = match ? tg : (tg ^ (TW'(1) << $urandom_range(0, TW - 1)));
    init     = 1'b1;
    next     = 1'($urandom_range(0, 1));
    @(negedge clk);
    init = 1'b0;
    next = 1'b0;

    for (int c = 0; c < 3000 && !done; c++) begin
      if (tag_valid || error) begin
        done = 1'b1;
      end else begin
        if (ready && (phase == 2'd0 || phase == 2'd3)) bad_ready = 1'b1;
        if (lat < 0 && ready && (phase == 2'd1 || phase == 2'd2)) lat = c + 1;
        if (ready && (phase == 2'd1 || phase == 2'd2))
          next = ($urandom_range(0, 2) != 0);
        else
          next = ($urandom_range(0, 5) == 0);
        init = ($urandom_range(0, 9) == 0);
        @(negedge clk);
        init = 1'b0;
        next = 1'b0;
      end
    end

    check_val({nm, ".done"},  TW'(done), TW'(1));
    check_val({nm, ".err"},   TW'(error), TW'(exp_err));
    check_val({nm, ".tv"},    TW'(tag_valid), TW'(!exp_err));
    check_val({nm, ".tc"},    TW'(tag_correct), TW'(!exp_err && !enc && match));
    check_val({nm, ".rdy"},   TW'(bad_ready), TW'(0));
    check_val({nm, ".viol"},  TW'(viol - viol0), TW'(0));
    check_val({nm, ".nev"},   TW'(ev_q.size() - ev_start), TW'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && (ev_start + i) < ev_q.size(); i++)
      check_val($sformatf("%s.ev%0d", nm, i), TW'(ev_q[ev_start + i]), TW'(exp_q[i]));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int lat;
    int ev_mark;
    bit seen;

    reset    = 1'b1;
    init     = 1'b0;
    next     = 1'b0;
    encdec   = 1'b0;
    aad_len  = '0;
    data_len = '0;
    tag_in   = '0;
    repeat (3) @(negedge clk);
    check_val("rst.ready", TW'(ready), TW'(1));
    check_val("rst.phase", TW'(phase), TW'(0));
    check_val("rst.ctr",   TW'(cc_ctr), TW'(0));
    check_val("rst.puls",  TW'({cc_init, cc_next, p_init, p_next, p_final}), TW'(0));
    check_val("rst.blen",  TW'(p_blen), TW'(0));
    check_val("rst.stat",  TW'({tag_valid, tag_correct, error}), TW'(0));
    reset = 1'b0;
    @(negedge clk);

    // RFC 8439 AEAD vector with instant engines: also checks init->ready latency.
    max_busy = 0;
    run_msg(1'b1, 12, 114, RFC_TAG, 1'b1, "rfc_enc", lat);
    check_val("rfc_enc.lat", TW'(lat), TW'(5));
    max_busy = 3;
    run_msg(1'b0, 12, 114, RFC_TAG, 1'b1, "rfc_dec_ok", lat);
    run_msg(1'b0, 12, 114, RFC_TAG, 1'b0, "rfc_dec_bad", lat);
    run_msg(1'b1, 0, 0, RFC_TAG, 1'b1, "empty", lat);
    run_msg(1'b0, 0, 0, RFC_TAG, 1'b1, "empty_dec", lat);
    run_msg(1'b1, 0, 193, RFC_TAG, 1'b1, "ovf193", lat);
    run_msg(1'b1, 0, 192, RFC_TAG, 1'b1, "max192", lat);
    run_msg(1'b0, 64, 1, RFC_TAG, 1'b1, "aad64", lat);

    // Reset while the keystream block is being computed.
    @(negedge clk);
    encdec   = 1'b1;
    aad_len  = '0;
    data_len = LW'(128);
    init     = 1'b1;
    @(negedge clk);
    init = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      if (cc_next) seen = 1'b1;
      else begin
        next = ready;
        @(negedge clk);
        next = 1'b0;
      end
    end
    check_val("mid.seen", TW'(seen), TW'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("mid.ready", TW'(ready), TW'(1));
    check_val("mid.puls",  TW'({cc_init, cc_next, p_init, p_next, p_final}), TW'(0));
    check_val("mid.tv",    TW'(tag_valid), TW'(0));
    ev_mark = ev_q.size();
    repeat (6) @(negedge clk);
    check_val("mid.quiet", TW'(ev_q.size() - ev_mark), TW'(0));
    run_msg(1'b0, 20, 100, RFC_TAG, 1'b1, "after_rst", lat);

    // Randomized messages.
    for (int i = 0; i < 30; i++) begin
      logic [TW-1:0] tg;
      tg = {$urandom, $urandom, $urandom, $urandom};
      max_busy = int'($urandom_range(0, 3));
      run_msg(1'($urandom_range(0, 1)), int'($urandom_range(0, 300)), int'($urandom_range(0, 260)),
              tg, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i), lat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
